// File: rtl/alu_issue_buf.sv
// alu_issue_buf: EX-stage issue buffer in front of the ALU.
// Decodes ALUOp/funct into the 4-bit ALU control code, pairs it with both
// operands and holds up to two operations in order behind valid/ready
// handshakes. in_ready_o depends only on the stored count, so no ready path
// runs combinationally from the ALU side back to ID/EX.
module alu_issue_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic              illegal_o
);

  localparam logic [CTRL_W-1:0] CTRL_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CTRL_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] CTRL_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] CTRL_BAD = CTRL_W'(4'b1111);

  // One buffered operation: decoded control code plus operands.
  typedef struct packed {
    logic              illegal;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } entry_t;

  entry_t      r_entry0;   // head
  entry_t      r_entry1;   // second in line
  logic [1:0]  r_count;    // occupancy, 0..2

  entry_t      w_new;
  logic        w_push;
  logic        w_pop;

  assign in_ready_o  = (r_count < 2'd2);
  assign out_valid_o = (r_count != 2'd0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  assign ctrl_o      = r_entry0.ctrl;
  assign src1_o      = r_entry0.src1;
  assign src2_o      = r_entry0.src2;
  assign illegal_o   = r_entry0.illegal;

  // Decode ALUOp/funct of the incoming operation; undecodable ops map to 1111.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_new.ctrl    = CTRL_BAD;
    w_new.illegal = 1'b1;
    w_new.src1    = src1_i;
    w_new.src2    = src2_i;
    case (aluop_i)
      3'b000: begin w_new.ctrl = CTRL_ADD; w_new.illegal = 1'b0; end
      3'b001: begin w_new.ctrl = CTRL_SUB; w_new.illegal = 1'b0; end
      3'b011: begin w_new.ctrl = CTRL_OR;  w_new.illegal = 1'b0; end
      3'b100: begin w_new.ctrl = CTRL_AND; w_new.illegal = 1'b0; end
      3'b101: begin w_new.ctrl = CTRL_SLT; w_new.illegal = 1'b0; end
      3'b010: begin
        case (funct_i)
          6'b100000: begin w_new.ctrl = CTRL_ADD; w_new.illegal = 1'b0; end
          6'b100010: begin w_new.ctrl = CTRL_SUB; w_new.illegal = 1'b0; end
          6'b100100: begin w_new.ctrl = CTRL_AND; w_new.illegal = 1'b0; end
          6'b100101: begin w_new.ctrl = CTRL_OR;  w_new.illegal = 1'b0; end
          6'b101010: begin w_new.ctrl = CTRL_SLT; w_new.illegal = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Two-entry in-order buffer: push at the tail, pop shifts entry 1 into the head.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: both entries are reset because the head outputs have defined reset values.
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_count  <= 2'd0;
    end else if (flush_i) begin
      // Flush discards occupancy only; head data keeps its last value.
      r_count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= w_new;
          else                 r_entry1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // Only shift when a second entry exists; otherwise the head holds its value.
          if (r_count == 2'd2) r_entry0 <= r_entry1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Only reachable with count=1: the new op replaces the departing head.
          r_entry0 <= w_new;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_buf.sv
// Directed testbench for alu_issue_buf: one task per scenario, inline checks.
module tb_alu_issue_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  aluop_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  ctrl_o;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  alu_issue_buf #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .aluop_i     (aluop_i),
    .funct_i     (funct_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
    .src1_o      (src1_o),
    .src2_o      (src2_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one operation for exactly one edge.
  task automatic push(input logic [2:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid_i = 1'b1;
    aluop_i    = op;
    funct_i    = fn;
    src1_i     = a;
    src2_i     = b;
    step();
    in_valid_i = 1'b0;
  endtask

  // Consume the head entry for exactly one edge.
  task automatic pop();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0; aluop_i = '0; funct_i = '0; src1_i = '0; src2_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b0;
    step(); step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal_o); end
    checks++; if (ctrl_o !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", ctrl_o); end
    checks++; if (src1_o !== 32'd0 || src2_o !== 32'd0) begin errors++; $display("FAIL reset_src: got %0d/%0d want 0/0", src1_o, src2_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic_push();
    push(3'b010, 6'b100010, 32'd9, 32'd4);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid_o); end
    checks++; if (ctrl_o !== 4'b0110) begin errors++; $display("FAIL basic_ctrl: got %b want 0110", ctrl_o); end
    checks++; if (src1_o !== 32'd9 || src2_o !== 32'd4) begin errors++; $display("FAIL basic_src: got %0d/%0d want 9/4", src1_o, src2_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL basic_illegal: got %b want 0", illegal_o); end
    pop();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", out_valid_o); end
    checks++; if (ctrl_o !== 4'b0110 || src1_o !== 32'd9) begin errors++; $display("FAIL basic_hold: got %b/%0d want 0110/9", ctrl_o, src1_o); end
  endtask

  task automatic test_back_to_back();
    // funct is ignored for non-R-type ops
    push(3'b000, 6'b111111, 32'd1, 32'd2);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", in_ready_o); end
    push(3'b011, 6'b000000, 32'd3, 32'd4);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready2: got %b want 0", in_ready_o); end
    push(3'b101, 6'b000000, 32'd5, 32'd6);
    checks++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_full: got ready=%b valid=%b want 0/1", in_ready_o, out_valid_o); end
    checks++; if (ctrl_o !== 4'b0010 || src1_o !== 32'd1) begin errors++; $display("FAIL b2b_head_stable: got %b/%0d want 0010/1", ctrl_o, src1_o); end
    pop();
    checks++; if (ctrl_o !== 4'b0001 || src1_o !== 32'd3 || out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b/%0d valid=%b want 0001/3/1", ctrl_o, src1_o, out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b want 1", in_ready_o); end
    pop();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_third_dropped: got valid=%b want 0", out_valid_o); end
  endtask

  task automatic test_push_pop();
    push(3'b000, 6'b000000, 32'd5, 32'd0);
    in_valid_i = 1'b1; aluop_i = 3'b100; funct_i = '0; src1_i = 32'd7; src2_i = 32'd8;
    out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin errors++; $display("FAIL pp_count1: got valid=%b ready=%b want 1/1", out_valid_o, in_ready_o); end
    checks++; if (ctrl_o !== 4'b0000 || src1_o !== 32'd7 || src2_o !== 32'd8) begin errors++; $display("FAIL pp_head: got %b/%0d/%0d want 0000/7/8", ctrl_o, src1_o, src2_o); end
    pop();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL pp_drained: got %b want 0", out_valid_o); end
  endtask

  task automatic test_illegal();
    push(3'b010, 6'b000000, 32'd10, 32'd11);
    push(3'b001, 6'b000000, 32'd12, 32'd13);
    checks++; if (ctrl_o !== 4'b1111 || illegal_o !== 1'b1) begin errors++; $display("FAIL ill_head: got %b/%b want 1111/1", ctrl_o, illegal_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL ill_buffered: got ready=%b want 0", in_ready_o); end
    pop();
    checks++; if (ctrl_o !== 4'b0110 || illegal_o !== 1'b0 || src1_o !== 32'd12) begin errors++; $display("FAIL ill_next: got %b/%b/%0d want 0110/0/12", ctrl_o, illegal_o, src1_o); end
    pop();
    push(3'b111, 6'b100000, 32'd14, 32'd15);
    checks++; if (ctrl_o !== 4'b1111 || illegal_o !== 1'b1) begin errors++; $display("FAIL ill_aluop: got %b/%b want 1111/1", ctrl_o, illegal_o); end
    pop();
  endtask

  task automatic test_flush();
    push(3'b000, 6'b000000, 32'd11, 32'd0);
    push(3'b011, 6'b000000, 32'd22, 32'd0);
    in_valid_i = 1'b1; aluop_i = 3'b101; src1_i = 32'd33;
    out_ready_i = 1'b1; flush_i = 1'b1;
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got valid=%b ready=%b want 0/1", out_valid_o, in_ready_o); end
    checks++; if (ctrl_o !== 4'b0010 || src1_o !== 32'd11) begin errors++; $display("FAIL flush_head_kept: got %b/%0d want 0010/11", ctrl_o, src1_o); end
    push(3'b100, 6'b000000, 32'd44, 32'd0);
    checks++; if (ctrl_o !== 4'b0000 || src1_o !== 32'd44 || out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_refill: got %b/%0d valid=%b want 0000/44/1", ctrl_o, src1_o, out_valid_o); end
    pop();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_count0: got valid=%b want 0", out_valid_o); end
  endtask

  task automatic test_async_reset();
    push(3'b000, 6'b000000, 32'd55, 32'd56);
    push(3'b011, 6'b000000, 32'd57, 32'd58);
    #3;
    rst_i = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL async_rst_state: got valid=%b ready=%b want 0/1", out_valid_o, in_ready_o); end
    checks++; if (ctrl_o !== 4'b0000 || src1_o !== 32'd0) begin errors++; $display("FAIL async_rst_data: got %b/%0d want 0000/0", ctrl_o, src1_o); end
    step();
    rst_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_back_to_back();
    test_push_pop();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
